encoder_8_to_3_irq: RTL

- Sequential 8-to-3 encoder; the reverse direction of the team's 3-to-8 decoder.
- Captures 8 one-hot or multi-hot request lines into a sticky pending register.
- Presents the index of the winning request as a registered 3-bit code with valid/ack handshake.
- Sits in front of a consumer that drives the 3-to-8 decoder back to per-source clear lines.

---
 rtl/encoder_8_to_3_irq_pkg.sv | 16 +
 rtl/encoder_8_to_3_irq_if.sv | 24 ++
 rtl/encoder_8_to_3_irq_prio.sv | 29 ++
 rtl/encoder_8_to_3_irq.sv | 67 ++++++
 4 files changed

// File: rtl/encoder_8_to_3_irq_pkg.sv
// Shared constants and helpers for the 8-to-3 interrupt encoder.
// The code width is tied to the number of request lines.
package enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Expands a granted index back into its pending-bit mask.
    function automatic logic [N_REQ-1:0] onehot3(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/encoder_8_to_3_irq_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
// The slave side is the encoder; the master side drives req/e/ack.
interface encoder_8_to_3_irq_if;
    import enc_pkg::*;

    logic             e;
    logic [N_REQ-1:0] req;
    logic             ack;
    logic [IDX_W-1:0] y;
    logic             valid;
    logic [N_REQ-1:0] pending;
    logic             any;

    modport master (
        output e, req, ack,
        input  y, valid, pending, any
    );

    modport slave (
        input  e, req, ack,
        output y, valid, pending, any
    );

endinterface

// File: rtl/encoder_8_to_3_irq_prio.sv
// Combinational 8-to-3 priority encoder; PRIO_HIGH selects whether the
// highest or the lowest set index wins.
module priority_encoder_8_to_3
    import enc_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] code,
    output logic             nonzero
);

    // The last match in scan order wins, so the scan direction sets priority.
    always_comb begin
        code = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (vec[i]) code = IDX_W'(i);
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (vec[i]) code = IDX_W'(i);
            end
        end
    end

    assign nonzero = |vec;

endmodule

// File: rtl/encoder_8_to_3_irq.sv
// Sticky 8-line interrupt capture with a registered priority grant and
// valid/ack handshake; acking a grant clears its pending bit.
module encoder_8_to_3_irq
    import enc_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder_8_to_3_irq_if.slave bus
);

    if (N_REQ != 8 || IDX_W != $clog2(N_REQ)) begin : g_size_check
        $error("encoder_8_to_3_irq supports only N_REQ=8, IDX_W=3");
    end

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pending_next;
    logic [IDX_W-1:0] win;
    logic             win_ok;

    // Reset asserts immediately but releases two clock edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    assign clr          = (bus.valid && bus.ack) ? onehot3(bus.y) : '0;
    assign pending_next = (bus.pending & ~clr) | (bus.e ? bus.req : '0);

    priority_encoder_8_to_3 #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_prio (
        .vec     (pending_next),
        .code    (win),
        .nonzero (win_ok)
    );

    // A presented grant is frozen until acked; the next winner loads on the ack edge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bus.pending <= '0;
            bus.any     <= 1'b0;
            bus.y       <= '0;
            bus.valid   <= 1'b0;
        end else begin
            bus.pending <= pending_next;
            bus.any     <= |pending_next;
            if (!bus.valid || bus.ack) begin
                if (bus.e && win_ok) begin
                    bus.valid <= 1'b1;
                    bus.y     <= win;
                end else begin
                    bus.valid <= 1'b0;
                end
            end
        end
    end

endmodule
